// File: rtl/mp_add_ctrl_pkg.sv
// Shared types and default sizing for the multi-precision add/sub controller.
// Operands are K words of N bits, processed one word per clock.
package mp_add_pkg;

   localparam int DEF_N = 8;
   localparam int DEF_K = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mp_add_ctrl_if.sv
// Request/result bundle between a requester (master) and the controller (slave).
// One request is carried at a time; busy/done report progress.
interface mp_add_ctrl_if #(
   parameter int N = mp_add_pkg::DEF_N,
   parameter int K = mp_add_pkg::DEF_K
);

   logic           start;
   logic           sub;
   logic [N*K-1:0] x;
   logic [N*K-1:0] y;
   logic           busy;
   logic           done;
   logic [N*K-1:0] s;
   logic           carryout;
   logic           overflow;

   modport master (
      output start, sub, x, y,
      input  busy, done, s, carryout, overflow
   );

   modport slave (
      input  start, sub, x, y,
      output busy, done, s, carryout, overflow
   );

endinterface

// File: rtl/mp_add_ctrl_word_adder.sv
// Stateless N-bit adder slice shared across all words of an operation.
// Subtraction is handled by the caller through operand inversion and carry-in.
module word_adder #(
   parameter int N = mp_add_pkg::DEF_N
) (
   input  logic         carryin,
   input  logic [N-1:0] X,
   input  logic [N-1:0] Y,
   output logic [N-1:0] S,
   output logic         carryout
);

   logic [N:0] sum;

   assign sum      = {1'b0, X} + {1'b0, Y} + {{N{1'b0}}, carryin};
   assign S        = sum[N-1:0];
   assign carryout = sum[N];

endmodule

// File: rtl/mp_add_ctrl.sv
// Word-serial add/subtract of two N*K-bit operands through one N-bit slice.
// Start latches the operands; K RUN cycles later the result is presented with a Done pulse.
module mp_add_ctrl
   import mp_add_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int K = DEF_K
) (
   input  logic         clk,
   input  logic         rst,
   mp_add_ctrl_if.slave bus
);

   localparam int W  = N * K;
   localparam int IW = (K > 1) ? $clog2(K) : 1;
   localparam int BW = (W > 1) ? $clog2(W) : 1;
   localparam logic [IW-1:0] LAST = IW'(K - 1);

   state_t state;
   state_t nextState;

   logic [IW-1:0] idx;
   logic          carry;
   logic          subReg;
   logic [W-1:0]  xReg;
   logic [W-1:0]  yReg;
   logic [W-1:0]  sReg;
   logic          carryoutReg;
   logic          overflowReg;

   logic [BW-1:0] base;
   logic [N-1:0]  aWord;
   logic [N-1:0]  bWord;
   logic [N-1:0]  sumWord;
   logic          sliceCarry;

   // Bit offset of the current word; Y is inverted here so the slice only ever adds.
   assign base  = BW'(idx) * BW'(N);
   assign aWord = xReg[base +: N];
   assign bWord = yReg[base +: N] ^ {N{subReg}};

   word_adder #(.N(N)) slice (
      .carryin  (carry),
      .X        (aWord),
      .Y        (bWord),
      .S        (sumWord),
      .carryout (sliceCarry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:    if (bus.start) nextState = RUN;
         RUN:     if (idx == LAST) nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = 1'b0;
      bus.done = 1'b0;
      unique case (state)
         RUN: begin
            bus.busy = 1'b1;
         end
         DONE: begin
            bus.busy = 1'b1;
            bus.done = 1'b1;
         end
         default: begin
            bus.busy = 1'b0;
            bus.done = 1'b0;
         end
      endcase
   end

   // Seeding carry with sub supplies the +1 of the two's-complement negation of Y.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx         <= '0;
         carry       <= 1'b0;
         subReg      <= 1'b0;
         xReg        <= '0;
         yReg        <= '0;
         sReg        <= '0;
         carryoutReg <= 1'b0;
         overflowReg <= 1'b0;
      end else begin
         if (state == IDLE && bus.start) begin
            xReg   <= bus.x;
            yReg   <= bus.y;
            subReg <= bus.sub;
            idx    <= '0;
            carry  <= bus.sub;
         end else if (state == RUN) begin
            sReg[base +: N] <= sumWord;
            carry           <= sliceCarry;
            if (idx == LAST) begin
               carryoutReg <= sliceCarry;
               overflowReg <= (aWord[N-1] & bWord[N-1] & ~sumWord[N-1])
                            | (~aWord[N-1] & ~bWord[N-1] & sumWord[N-1]);
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

   assign bus.s        = sReg;
   assign bus.carryout = carryoutReg;
   assign bus.overflow = overflowReg;

endmodule

// File: tb/tb_mp_add_ctrl.sv
// Directed and random checks of mp_add_ctrl (N=8, K=4) against an arithmetic reference model.
// Results, latency, Busy/Done behaviour and reset clearing are compared with immediate assertions.
module tb_mp_add_ctrl;
   import mp_add_pkg::*;

   localparam int N = 8;
   localparam int K = 4;
   localparam int W = N * K;
   localparam int MAXWAIT = 4 * K + 8;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   mp_add_ctrl_if #(.N(N), .K(K)) bus ();

   mp_add_ctrl #(.N(N), .K(K)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference arithmetic: unsigned carry/no-borrow and signed overflow from operand signs.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb,
                                 output logic [W-1:0] rs, output logic rc, output logic rv);
      logic [W:0] full;
      if (!sb) begin
         full = {1'b0, a} + {1'b0, b};
         rs   = full[W-1:0];
         rc   = full[W];
         rv   = (a[W-1] == b[W-1]) && (rs[W-1] != a[W-1]);
      end else begin
         rs = a - b;
         rc = (a >= b);
         rv = (a[W-1] != b[W-1]) && (rs[W-1] != a[W-1]);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb);
      bus.x     = a;
      bus.y     = b;
      bus.sub   = sb;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.x     = W'($urandom);
      bus.y     = W'($urandom);
      bus.sub   = 1'($urandom);
   endtask

   task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb,
                        input string tag, input bit repulse);
      logic [W-1:0] expS;
      logic         expC;
      logic         expV;
      int           lat;
      model(a, b, sb, expS, expC, expV);
      applyStimulus(a, b, sb);
      if (repulse) begin
         bus.x     = '0;
         bus.y     = '0;
         bus.start = 1'b1;
      end
      lat = 0;
      while (bus.done !== 1'b1 && lat < MAXWAIT) begin
         checkOutput({tag, ".busyRun"}, 64'(bus.busy), 64'(1));
         tick();
         lat++;
      end
      bus.start = 1'b0;
      checkOutput({tag, ".latency"}, 64'(lat), 64'(K));
      checkOutput({tag, ".s"}, 64'(bus.s), 64'(expS));
      checkOutput({tag, ".carryout"}, 64'(bus.carryout), 64'(expC));
      checkOutput({tag, ".overflow"}, 64'(bus.overflow), 64'(expV));
      checkOutput({tag, ".busyDone"}, 64'(bus.busy), 64'(1));
      tick();
      checkOutput({tag, ".donePulse"}, 64'(bus.done), 64'(0));
      checkOutput({tag, ".busyIdle"}, 64'(bus.busy), 64'(0));
      checkOutput({tag, ".sHold"}, 64'(bus.s), 64'(expS));
      tick();
      checkOutput({tag, ".noSecondDone"}, 64'(bus.done), 64'(0));
      checkOutput({tag, ".carryHold"}, 64'(bus.carryout), 64'(expC));
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.x     = '0;
      bus.y     = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.s", 64'(bus.s), 64'(0));
      checkOutput("reset.carryout", 64'(bus.carryout), 64'(0));
      checkOutput("reset.overflow", 64'(bus.overflow), 64'(0));
      checkOutput("reset.busy", 64'(bus.busy), 64'(0));
      checkOutput("reset.done", 64'(bus.done), 64'(0));
      rst = 1'b0;
      tick();

      runOp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "addWrap", 1'b0);
      runOp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "addOvf", 1'b0);
      runOp(32'h0000_0005, 32'h0000_0007, 1'b1, "subBorrow", 1'b0);
      runOp(32'h8000_0000, 32'h0000_0001, 1'b1, "subOvf", 1'b0);
      runOp(32'h1234_5678, 32'h0FED_CBA9, 1'b0, "repulse", 1'b1);

      // Reset two cycles into RUN must discard the partial result.
      applyStimulus(32'hDEAD_BEEF, 32'h1111_1111, 1'b0);
      tick();
      rst = 1'b1;
      #1;
      checkOutput("midReset.s", 64'(bus.s), 64'(0));
      checkOutput("midReset.carryout", 64'(bus.carryout), 64'(0));
      checkOutput("midReset.overflow", 64'(bus.overflow), 64'(0));
      checkOutput("midReset.busy", 64'(bus.busy), 64'(0));
      checkOutput("midReset.done", 64'(bus.done), 64'(0));
      checkOutput("midReset.state", 64'(dut.state), 64'(IDLE));
      tick();
      rst = 1'b0;
      tick();
      runOp(32'h0000_0003, 32'h0000_0004, 1'b0, "afterReset", 1'b0);

      runOp(32'h0000_0000, 32'h0000_0000, 1'b1, "subZero", 1'b0);
      runOp(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, "subMax", 1'b0);

      for (int i = 0; i < 16; i++) begin
         runOp(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rand%0d", i), 1'b0);
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mp_add_ctrl.md
MP_ADD_CTRL -- requirements
Module: mp_add_ctrl

Interface
REQ-001 The block SHALL have parameters: N, default 8, word width of the shared adder slice; K, default 4, number of words per operand (K >= 1).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
  Clock  input  1  rising-edge clock
  Reset  input  1  asynchronous, active-high reset
  Start  input  1  request pulse; sampled only in IDLE
  Sub    input  1  0 = X+Y, 1 = X-Y; latched with Start
  X      input  N*K  operand A, word 0 = bits N-1:0; latched with Start
  Y      input  N*K  operand B; latched with Start
  Busy   output 1  high in RUN and DONE
  Done   output 1  one-cycle completion pulse
  S      output N*K  result
  Carryout output 1  carry out of the top word
  Overflow output 1  two's-complement overflow of the full N*K result

Function
REQ-003 The FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-004 In IDLE with Start=1 at an edge, the block SHALL latch X, Y and Sub, clear the word index to 0, set the internal carry to Sub, and enter RUN.
REQ-005 In RUN, each edge SHALL process word idx through one N-bit adder slice: operand A word, operand B word (bitwise inverted if Sub), carry-in = registered carry.
REQ-006 On that edge the block SHALL write the sum into S word idx, register the slice carry-out, and increment idx.
REQ-007 After word K-1 is written, the block SHALL enter DONE, set Carryout to the final slice carry, and set Overflow = (a & b & ~s) | (~a & ~b & s) on bit N-1 of the top word, using the effective (possibly inverted) b.
REQ-008 Done SHALL be high for exactly the one cycle spent in DONE; the next edge SHALL return to IDLE.
REQ-009 Latency: Start sampled at edge 0 → Done high in the cycle after edge K. Throughput is one operation per K+2 cycles.
REQ-010 Start SHALL be ignored in RUN and DONE; no queueing.
REQ-011 X, Y and Sub changes after the Start edge SHALL NOT affect the operation in progress.
REQ-012 S, Carryout and Overflow SHALL hold their values from Done until overwritten by the next operation. S is valid only from DONE onward.
REQ-013 The idx counter SHALL be $clog2(K) bits, minimum 1. It SHALL never exceed K-1, and SHALL reset to 0 on every accepted Start.
REQ-014 For subtraction, Carryout=1 SHALL mean no borrow (X >= Y unsigned).
REQ-015 With K=1 the block SHALL spend exactly one cycle in RUN.

Reset
REQ-016 When Reset is asserted, at any time including mid-RUN, the block SHALL asynchronously force state IDLE and clear idx, the internal carry, S, Carryout, Overflow, Busy and Done to 0.
REQ-017 Any partial result SHALL be discarded on reset.
REQ-018 The first Start after Reset deasserts SHALL be accepted normally.

Structure
REQ-019 Package mp_add_pkg SHALL hold the state enum (IDLE, RUN, DONE) and default N/K constants.
REQ-020 The N-bit slice SHALL be a separate combinational sub-module word_adder. It SHALL have ports carryin, X, Y, S, carryout; it SHALL contain no state.
REQ-021 All registers SHALL reside in mp_add_ctrl.
REQ-022 Operand word selection SHALL use indexed part-select on idx.

Verification (N=8, K=4)
REQ-023 X=32'hFFFFFFFF, Y=1, Sub=0 → S=0, Carryout=1, Overflow=0, with Done high exactly 4 cycles after the Start edge.
REQ-024 X=32'h7FFFFFFF, Y=1, Sub=0 → S=32'h80000000, Carryout=0, Overflow=1.
REQ-025 X=5, Y=7, Sub=1 → S=32'hFFFFFFFE, Carryout=0, Overflow=0.
REQ-026 X=32'h80000000, Y=1, Sub=1 → S=32'h7FFFFFFF, Carryout=1, Overflow=1.
REQ-027 Start re-pulsed during RUN with X=Y=0 → the first result is unchanged, there is exactly one Done pulse, and Busy stays high until IDLE.
REQ-028 Reset asserted 2 cycles into RUN → all outputs are 0 and the state is IDLE. A following Start with X=3, Y=4 → S=7, Done after 4 cycles.
